// File: rtl/cache_ctrl_pkg.sv
// Shared types and widths for the 2-way cache miss controller.
package cache_ctrl_pkg;

    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned S_INDEX  = 3;
    localparam int unsigned S_TAG    = 24;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        RESPOND   = 2'd3
    } state_e;

    typedef logic way_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Three saturating event counters (hits, misses, writebacks) with
// single-cycle increment strobes, cleared by the synchronous reset.
import cache_ctrl_pkg::*;

module cache_perf_cnt (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_inc_i,
    input  logic             miss_inc_i,
    input  logic             wb_inc_i,
    output logic [CNT_W-1:0] hits_o,
    output logic [CNT_W-1:0] misses_o,
    output logic [CNT_W-1:0] wbs_o
);

    logic [CNT_W-1:0] hits_q,   hits_d;
    logic [CNT_W-1:0] misses_q, misses_d;
    logic [CNT_W-1:0] wbs_q,    wbs_d;

    // Next counter values: bump on strobe, saturating at all-ones.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbs_d    = wbs_q;
        if (hit_inc_i) begin
            hits_d = sat_inc(hits_q);
        end else begin
            hits_d = hits_q;
        end
        if (miss_inc_i) begin
            misses_d = sat_inc(misses_q);
        end else begin
            misses_d = misses_q;
        end
        if (wb_inc_i) begin
            wbs_d = sat_inc(wbs_q);
        end else begin
            wbs_d = wbs_q;
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= {CNT_W{1'b0}};
            misses_q <= {CNT_W{1'b0}};
            wbs_q    <= {CNT_W{1'b0}};
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbs_q    <= wbs_d;
        end
    end

    assign hits_o   = hits_q;
    assign misses_o = misses_q;
    assign wbs_o    = wbs_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss controller for a 2-way cache: hit response, dirty-victim writeback,
// line fill and PLRU MRU update, one outstanding request at a time.
// Optional feature macro: CACHE_PERF_CNT_EN enables the perf_* counters;
// without it the perf_* ports read constant zero.
import cache_ctrl_pkg::*;

module cache_miss_ctrl #(
    parameter int unsigned s_offset = S_OFFSET,
    parameter int unsigned s_index  = S_INDEX,
    parameter int unsigned s_tag    = S_TAG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_address,
    input  logic                 hit,
    input  logic                 hit_way,
    input  logic                 plru_way,
    input  logic [1:0]           victim_valid,
    input  logic [1:0]           victim_dirty,
    input  logic [2*s_tag-1:0]   victim_tag,
    output logic                 mem_resp,
    output logic                 way_sel,
    output logic                 data_load,
    output logic                 tag_load,
    output logic                 valid_load,
    output logic                 dirty_load,
    output logic                 dirty_in,
    output logic                 plru_load,
    output logic                 plru_mru,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    input  logic                 pmem_resp,
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses,
    output logic [31:0]          perf_wbs
);

    state_e             state_q, state_d;
    way_t               way_q,   way_d;
    logic               req_s;
    logic [s_index-1:0] index_s;
    logic [s_tag-1:0]   req_tag_s;
    logic [s_tag-1:0]   victim_tag_s;
    logic               unused_s;

    assign req_s        = mem_read | mem_write;
    assign index_s      = mem_address[s_offset +: s_index];
    assign req_tag_s    = mem_address[31 -: s_tag];
    assign victim_tag_s = way_q ? victim_tag[2*s_tag-1:s_tag] : victim_tag[s_tag-1:0];
    assign unused_s     = ^mem_address[s_offset-1:0];

    // State and latched way registers; reset returns to IDLE and clears the way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            way_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
        end
    end

    // Next-state logic; the victim way is captured only at the miss decision.
    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (hit) begin
                        state_d = RESPOND;
                        way_d   = hit_way;
                    end else begin
                        way_d = plru_way;
                        if (victim_valid[plru_way] & victim_dirty[plru_way]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = FILL;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_d = RESPOND;
                end else begin
                    state_d = FILL;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                way_d   = 1'b0;
            end
        endcase
    end

    // Output decode from the current state; fill loads fire in the pmem_resp cycle.
    always_comb begin
        mem_resp     = 1'b0;
        way_sel      = 1'b0;
        data_load    = 1'b0;
        tag_load     = 1'b0;
        valid_load   = 1'b0;
        dirty_load   = 1'b0;
        dirty_in     = 1'b0;
        plru_load    = 1'b0;
        plru_mru     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        case (state_q)
            IDLE: begin
                mem_resp = 1'b0;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag_s, index_s, {s_offset{1'b0}}};
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag_s, index_s, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    data_load  = 1'b1;
                    tag_load   = 1'b1;
                    valid_load = 1'b1;
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                    way_sel    = way_q;
                end else begin
                    way_sel = 1'b0;
                end
            end
            RESPOND: begin
                mem_resp  = 1'b1;
                plru_load = 1'b1;
                plru_mru  = way_q;
                if (mem_write) begin
                    dirty_load = 1'b1;
                    dirty_in   = 1'b1;
                    way_sel    = way_q;
                end else begin
                    dirty_in = 1'b0;
                end
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic hit_inc_s;
    logic miss_inc_s;
    logic wb_inc_s;

    assign hit_inc_s  = (state_q == IDLE) & req_s & hit;
    assign miss_inc_s = (state_q == IDLE) & req_s & ~hit;
    assign wb_inc_s   = (state_q == WRITEBACK) & pmem_resp;

    cache_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .hit_inc_i  (hit_inc_s),
        .miss_inc_i (miss_inc_s),
        .wb_inc_i   (wb_inc_s),
        .hits_o     (perf_hits),
        .misses_o   (perf_misses),
        .wbs_o      (perf_wbs)
    );
`else
    assign perf_hits   = 32'd0;
    assign perf_misses = 32'd0;
    assign perf_wbs    = 32'd0;
`endif

endmodule
